// File: rtl/alu_share_pkg.sv
// Shared types and helpers for the shared-ALU sequencer.
package alu_share_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned ALU_SEL_W = 4;
    localparam int unsigned STAT_W    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Round-robin pointer advance with wrap at nreq.
    function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned nreq);
        return (ptr + 1 >= nreq) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// Combinational RV32I ALU; data_sel is {funct7[5], funct3}, unknown codes yield zero.
module alu
    import alu_share_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0]      a,
    input  logic [XLEN-1:0]      b,
    input  logic [ALU_SEL_W-1:0] data_sel,
    output logic [XLEN-1:0]      res
);

    localparam int unsigned SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;

    assign shamt = b[SH_W-1:0];

    always_comb begin
        res = '0;
        case (data_sel)
            4'b0000: res = a + b;
            4'b1000: res = a - b;
            4'b0001: res = a << shamt;
            4'b0010: res = XLEN'($signed(a) < $signed(b));
            4'b0011: res = XLEN'(a < b);
            4'b0100: res = a ^ b;
            4'b0101: res = a >> shamt;
            4'b1101: res = XLEN'($signed(a) >>> shamt);
            4'b0110: res = a | b;
            4'b0111: res = a & b;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: first set request at or above ptr, wrapping around.
module rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic                    any
);

    localparam int unsigned ID_W = $clog2(NREQ);

    always_comb begin
        int unsigned idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!any && req[ID_W'(idx)]) begin
                grant[ID_W'(idx)] = 1'b1;
                grant_idx         = ID_W'(idx);
                any               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU among NREQ requesters: round-robin grant, one op in flight, tagged response.
// Defining ALU_SHARE_STATS_EN adds grant_cnt/stall_cnt saturating counters.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned XLEN        = XLEN_DEF,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*XLEN-1:0]      req_a,
    input  logic [NREQ*XLEN-1:0]      req_b,
    input  logic [NREQ*ALU_SEL_W-1:0] req_sel,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [XLEN-1:0]           resp_data,
    output logic [$clog2(NREQ)-1:0]   resp_id,
    output logic                      busy
`ifdef ALU_SHARE_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0]    grant_cnt,
    output logic [STAT_W-1:0]         stall_cnt
`endif
);

    localparam int unsigned ID_W  = $clog2(NREQ);
    localparam int unsigned CNT_W = $clog2(EXEC_CYCLES) + 1;

    if (NREQ < 2 || EXEC_CYCLES < 1) begin : g_bad_cfg
        $fatal(1, "alu_share_ctrl: requires NREQ >= 2 and EXEC_CYCLES >= 1");
    end

    state_t                 state;
    logic [ID_W-1:0]        rr_ptr;
    logic [CNT_W-1:0]       cnt;
    logic [XLEN-1:0]        op_a;
    logic [XLEN-1:0]        op_b;
    logic [ALU_SEL_W-1:0]   op_sel;
    logic [ID_W-1:0]        op_id;
    logic [XLEN-1:0]        alu_res;

    logic [NREQ-1:0]        arb_grant;
    logic [ID_W-1:0]        arb_idx;
    logic                   arb_any;

    logic [XLEN-1:0]        a_vec   [NREQ];
    logic [XLEN-1:0]        b_vec   [NREQ];
    logic [ALU_SEL_W-1:0]   sel_vec [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_vec[i]   = req_a[i*XLEN +: XLEN];
        assign b_vec[i]   = req_b[i*XLEN +: XLEN];
        assign sel_vec[i] = req_sel[i*ALU_SEL_W +: ALU_SEL_W];
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // ALU sees only the captured operands, so it is stable for the whole of EXEC.
    alu #(.XLEN(XLEN)) u_alu (
        .a        (op_a),
        .b        (op_b),
        .data_sel (op_sel),
        .res      (alu_res)
    );

    // Accept is combinational so the requester sees it in its request cycle.
    always_comb begin
        req_ready = '0;
        if (state == IDLE) begin
            req_ready = arb_grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_sel     <= '0;
            op_id      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        op_a   <= a_vec[arb_idx];
                        op_b   <= b_vec[arb_idx];
                        op_sel <= sel_vec[arb_idx];
                        op_id  <= arb_idx;
                        rr_ptr <= ID_W'(next_rr(32'(arb_idx), NREQ));
                        cnt    <= CNT_W'(EXEC_CYCLES - 1);
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        resp_data  <= alu_res;
                        resp_id    <= op_id;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SHARE_STATS_EN
    // Stall means a request is pending while the ALU is occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (state == IDLE && arb_any &&
                grant_cnt[32'(arb_idx)*STAT_W +: STAT_W] != {STAT_W{1'b1}}) begin
                grant_cnt[32'(arb_idx)*STAT_W +: STAT_W] <=
                    grant_cnt[32'(arb_idx)*STAT_W +: STAT_W] + STAT_W'(1);
            end
            if (state != IDLE && (|req_valid) && stall_cnt != {STAT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench: EXEC_CYCLES=1/NREQ=2 and EXEC_CYCLES=3/NREQ=3 instances share stimulus.
module tb_alu_share_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]  rv;
    logic [95:0] ra;
    logic [95:0] rb;
    logic [11:0] rs;
    logic        rresp;

    logic [1:0]  rdy1;
    logic        val1;
    logic [31:0] data1;
    logic        id1;
    logic        busy1;

    logic [2:0]  rdy3;
    logic        val3;
    logic [31:0] data3;
    logic [1:0]  id3;
    logic        busy3;

`ifdef ALU_SHARE_STATS_EN
    logic [31:0] gc1;
    logic [15:0] sc1;
    logic [47:0] gc3;
    logic [15:0] sc3;
`endif

    alu_share_ctrl #(.NREQ(2), .XLEN(32), .EXEC_CYCLES(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (rv[1:0]),
        .req_ready  (rdy1),
        .req_a      (ra[63:0]),
        .req_b      (rb[63:0]),
        .req_sel    (rs[7:0]),
        .resp_valid (val1),
        .resp_ready (rresp),
        .resp_data  (data1),
        .resp_id    (id1),
        .busy       (busy1)
`ifdef ALU_SHARE_STATS_EN
        ,
        .grant_cnt  (gc1),
        .stall_cnt  (sc1)
`endif
    );

    alu_share_ctrl #(.NREQ(3), .XLEN(32), .EXEC_CYCLES(3)) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (rv),
        .req_ready  (rdy3),
        .req_a      (ra),
        .req_b      (rb),
        .req_sel    (rs),
        .resp_valid (val3),
        .resp_ready (rresp),
        .resp_data  (data3),
        .resp_id    (id3),
        .busy       (busy3)
`ifdef ALU_SHARE_STATS_EN
        ,
        .grant_cnt  (gc3),
        .stall_cnt  (sc3)
`endif
    );

    // Observation mux: sel_dut picks which instance the current step checks.
    bit          sel_dut;
    logic [2:0]  o_rdy;
    logic        o_val;
    logic [31:0] o_data;
    logic [1:0]  o_id;
    logic        o_busy;
    assign o_rdy  = sel_dut ? rdy3  : {1'b0, rdy1};
    assign o_val  = sel_dut ? val3  : val1;
    assign o_data = sel_dut ? data3 : data1;
    assign o_id   = sel_dut ? id3   : {1'b0, id1};
    assign o_busy = sel_dut ? busy3 : busy1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          ptr_m;
    int          gnt_m [3];
    int          stall_m;
    logic [31:0] opa [3];
    logic [31:0] opb [3];
    logic [3:0]  ops [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] s);
        int unsigned sh;
        sh = 32'(b[4:0]);
        case (s)
            4'h0: return a + b;
            4'h8: return a - b;
            4'h1: return a << sh;
            4'h2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h3: return (a < b) ? 32'd1 : 32'd0;
            4'h4: return a ^ b;
            4'h5: return a >> sh;
            4'hD: return 32'($signed(a) >>> sh);
            4'h6: return a | b;
            4'h7: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int pick(input logic [2:0] mask, input int ptr, input int n);
        for (int k = 0; k < n; k++) begin
            if (mask[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < 3; i++) begin
            opa[i] = $urandom;
            opb[i] = $urandom;
            ops[i] = 4'($urandom);
        end
    endtask

    task automatic model_reset();
        ptr_m   = 0;
        stall_m = 0;
        for (int i = 0; i < 3; i++) gnt_m[i] = 0;
    endtask

    // One transaction from IDLE; called at posedge+1, returns at posedge+1 back in IDLE.
    task automatic do_op(input logic [2:0] mask, input logic [2:0] post, input int bp);
        int n;
        int ec;
        int g;
        logic [31:0] exp;
        n  = sel_dut ? 3 : 2;
        ec = sel_dut ? 3 : 1;
        g  = pick(mask, ptr_m, n);
        for (int i = 0; i < 3; i++) begin
            ra[i*32 +: 32] = opa[i];
            rb[i*32 +: 32] = opb[i];
            rs[i*4 +: 4]   = ops[i];
        end
        rv    = mask;
        rresp = (bp == 0);
        #1;
        chk("idle_busy", 32'(o_busy), 32'd0);
        chk("grant_ready", 32'(o_rdy), 32'(3'b001 << g));
        exp = alu_ref(opa[g], opb[g], ops[g]);
        gnt_m[g]++;
        @(posedge clk); #1;
        // Granted requester is free to change everything after the accept edge.
        rv = post;
        ra = {$urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom};
        rs = 12'($urandom);
        #1;
        for (int k = 0; k < ec; k++) begin
            chk("exec_no_valid", 32'(o_val), 32'd0);
            chk("exec_ready", 32'(o_rdy), 32'd0);
            chk("exec_busy", 32'(o_busy), 32'd1);
            @(posedge clk); #1;
        end
        chk("resp_valid", 32'(o_val), 32'd1);
        chk("resp_data", o_data, exp);
        chk("resp_id", 32'(o_id), 32'(g));
        for (int j = 0; j < bp; j++) begin
            chk("bp_ready", 32'(o_rdy), 32'd0);
            chk("bp_busy", 32'(o_busy), 32'd1);
            @(posedge clk); #1;
            chk("bp_valid", 32'(o_val), 32'd1);
            chk("bp_data", o_data, exp);
            chk("bp_id", 32'(o_id), 32'(g));
        end
        rresp = 1'b1;
        @(posedge clk); #1;
        chk("hs_valid", 32'(o_val), 32'd0);
        chk("hs_busy", 32'(o_busy), 32'd0);
        if (post != 3'b000) stall_m += ec + bp + 1;
        ptr_m = (g + 1) % n;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        rv    = '0;
        #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [2:0] m;
        logic [2:0] p;
        rst_n   = 1'b0;
        rv      = '0;
        ra      = '0;
        rb      = '0;
        rs      = '0;
        rresp   = 1'b0;
        sel_dut = 1'b0;
        model_reset();
        #2;
        chk("rst_valid1", 32'(val1), 32'd0);
        chk("rst_data1", data1, 32'd0);
        chk("rst_id1", 32'(id1), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_ready1", 32'(rdy1), 32'd0);
        chk("rst_valid3", 32'(val3), 32'd0);
        chk("rst_data3", data3, 32'd0);
        chk("rst_busy3", 32'(busy3), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single request, latency 1.
        opa[0] = 32'h2; opb[0] = 32'hFFFF_FFFF; ops[0] = 4'b1001;
        opa[1] = 32'h0; opb[1] = 32'h0;         ops[1] = 4'b0000;
        opa[2] = 32'h0; opb[2] = 32'h0;         ops[2] = 4'b0000;
        do_op(3'b001, 3'b000, 0);
        opa[0] = 32'h2; opb[0] = 32'hFFFF_FFFF; ops[0] = 4'b0000;
        do_op(3'b001, 3'b000, 0);

        // Both held valid: grants must alternate.
        for (int i = 0; i < 6; i++) begin
            rand_ops();
            do_op(3'b011, 3'b011, 0);
        end

        // Backpressure for 5 cycles.
        rand_ops();
        do_op(3'b010, 3'b000, 5);

`ifdef ALU_SHARE_STATS_EN
        chk("grant_cnt0", 32'(gc1[15:0]), 32'(gnt_m[0]));
        chk("grant_cnt1", 32'(gc1[31:16]), 32'(gnt_m[1]));
        chk("stall_cnt", 32'(sc1), 32'(stall_m));
`endif

        // Switch to the 3-cycle, 3-requester instance.
        sel_dut = 1'b1;
        pulse_reset();
        rand_ops();
        do_op(3'b010, 3'b000, 0);

        // Reset during EXEC drops the in-flight op and the pointer.
        rand_ops();
        for (int i = 0; i < 3; i++) begin
            ra[i*32 +: 32] = opa[i];
            rb[i*32 +: 32] = opb[i];
            rs[i*4 +: 4]   = ops[i];
        end
        rv = 3'b100;
        @(posedge clk); #1;
        rv = 3'b000;
        chk("pre_rst_busy", 32'(busy3), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(val3), 32'd0);
        chk("async_rst_busy", 32'(busy3), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("no_resp_after_rst", 32'(val3), 32'd0);
        end
        rand_ops();
        do_op(3'b110, 3'b000, 0);
        rand_ops();
        do_op(3'b111, 3'b000, 1);

        // Randomized traffic.
        for (int i = 0; i < 30; i++) begin
            rand_ops();
            m = 3'($urandom_range(1, 7));
            p = 3'($urandom_range(0, 7));
            do_op(m, p, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
